alpha_recursion: RTL and testbench

Parametrised forward state-metric (alpha) unit for the 8-state max-log-MAP SISO decoder, the successor to the fixed-width alpha block. It consumes one branch-metric pair (gamma1, gamma2) per trellis step and emits the alpha vector that applies to that step. Feeds the LLR stage alongside the beta unit.

---
 rtl/siso_pkg.sv | 33 +++
 rtl/alpha_acs.sv | 34 +++
 rtl/alpha_recursion.sv | 198 +++++++++++++++++++
 tb/tb_alpha_recursion.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared definitions for the 8-state max-log-MAP SISO datapath:
// state count, FSM encoding, default widths and the trellis tables.
package siso_pkg;

    localparam int NUM_STATES   = 8;
    localparam int DEF_BRANCH_W = 16;
    localparam int DEF_METRIC_W = 19;
    localparam int DEF_LEN_W    = 13;
    localparam int DEF_INIT_NEG = -128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    // Bit s set: destination s is driven by gamma2, else by gamma1.
    localparam logic [NUM_STATES-1:0] TRL_GSEL  = 8'b0110_0110;

    // Bit s set: first operand subtracts gamma, second adds it.
    localparam logic [NUM_STATES-1:0] TRL_NEG_A = 8'b0101_1010;

    // First source state feeding destination dst.
    function automatic int trl_src_a(input int dst);
        return (dst % 4) * 2;
    endfunction

    // Second source state feeding destination dst.
    function automatic int trl_src_b(input int dst);
        return (dst % 4) * 2 + 1;
    endfunction

endpackage

// File: rtl/alpha_acs.sv
// Add-compare-select for one destination state of the forward
// recursion; ties keep the first operand.
module alpha_acs
    import siso_pkg::*;
#(
    parameter int SUM_W = DEF_METRIC_W + 2,
    parameter bit GSEL  = 1'b0,
    parameter bit NEG_A = 1'b0
) (
    input  logic signed [SUM_W-1:0] a_first,
    input  logic signed [SUM_W-1:0] a_second,
    input  logic signed [SUM_W-1:0] g1,
    input  logic signed [SUM_W-1:0] g2,
    output logic signed [SUM_W-1:0] n
);

    logic signed [SUM_W-1:0] g;
    logic signed [SUM_W-1:0] p;
    logic signed [SUM_W-1:0] q;

    // Pick the branch metric, form both path sums, keep the larger.
    always_comb begin
        g = GSEL ? g2 : g1;
        if (NEG_A) begin
            p = a_first - g;
            q = a_second + g;
        end else begin
            p = a_first + g;
            q = a_second - g;
        end
        n = (p >= q) ? p : q;
    end

endmodule

// File: rtl/alpha_recursion.sv
// Forward state-metric (alpha) unit: one gamma pair in per trellis
// step, the alpha vector for that step out, with block framing.
module alpha_recursion
    import siso_pkg::*;
#(
    parameter int BRANCH_W  = DEF_BRANCH_W,
    parameter int METRIC_W  = DEF_METRIC_W,
    parameter int NORM_MODE = 0,
    parameter int INIT_NEG  = DEF_INIT_NEG,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [LEN_W-1:0]               blk_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [BRANCH_W-1:0]     gamma1,
    input  logic signed [BRANCH_W-1:0]     gamma2,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_STATES*METRIC_W-1:0] alpha_o,
    output logic [LEN_W-1:0]               out_idx,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

    localparam int SUM_W  = METRIC_W + 2;
    localparam int DIFF_W = SUM_W + 1;
    localparam int VEC_W  = NUM_STATES * METRIC_W;

    localparam logic signed [METRIC_W-1:0] INIT_M = METRIC_W'(INIT_NEG);

    localparam logic signed [DIFF_W-1:0] SAT_MAX =
        {4'b0000, {(METRIC_W-1){1'b1}}};
    localparam logic signed [DIFF_W-1:0] SAT_MIN =
        {4'b1111, {(METRIC_W-1){1'b0}}};

    fsm_state_t state_q;
    fsm_state_t state_d;

    logic signed [METRIC_W-1:0] metric_q [NUM_STATES];
    logic signed [METRIC_W-1:0] next_m   [NUM_STATES];
    logic signed [SUM_W-1:0]    ext_m    [NUM_STATES];
    logic signed [SUM_W-1:0]    n_raw    [NUM_STATES];
    logic signed [SUM_W-1:0]    norm_ref;
    logic signed [SUM_W-1:0]    g1_x;
    logic signed [SUM_W-1:0]    g2_x;

    logic [VEC_W-1:0] cur_pack;
    logic [LEN_W-1:0] k_q;
    logic [LEN_W-1:0] len_q;
    logic             zdone_q;
    logic             accept;
    logic             xfer;
    logic             last_k;

    function automatic logic signed [METRIC_W-1:0] sat_metric(
        input logic signed [DIFF_W-1:0] v
    );
        if (v > SAT_MAX) begin
            return SAT_MAX[METRIC_W-1:0];
        end
        if (v < SAT_MIN) begin
            return SAT_MIN[METRIC_W-1:0];
        end
        return v[METRIC_W-1:0];
    endfunction

    assign g1_x = SUM_W'(gamma1);
    assign g2_x = SUM_W'(gamma2);

    assign in_ready = (state_q == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !start;
    assign xfer     = out_valid && out_ready;
    assign last_k   = (k_q == len_q - LEN_W'(1));
    assign busy     = (state_q != ST_IDLE);

    // Last-vector done is suppressed when a new block restarts the unit.
    assign done = zdone_q
                | (xfer && out_last && (state_q == ST_DRAIN) && !start);

    // Widen the stored metrics and run the eight ACS butterflies.
    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        localparam int SA = trl_src_a(s);
        localparam int SB = trl_src_b(s);

        assign ext_m[s] = SUM_W'(metric_q[s]);

        alpha_acs #(
            .SUM_W (SUM_W),
            .GSEL  (TRL_GSEL[s]),
            .NEG_A (TRL_NEG_A[s])
        ) u_acs (
            .a_first  (ext_m[SA]),
            .a_second (ext_m[SB]),
            .g1       (g1_x),
            .g2       (g2_x),
            .n        (n_raw[s])
        );
    end

    // Normalise against state 0 or the best state, then clip.
    always_comb begin
        norm_ref = n_raw[0];
        if (NORM_MODE == 1) begin
            for (int s = 1; s < NUM_STATES; s++) begin
                if (n_raw[s] > norm_ref) begin
                    norm_ref = n_raw[s];
                end
            end
        end
        for (int s = 0; s < NUM_STATES; s++) begin
            next_m[s] = sat_metric(DIFF_W'(n_raw[s]) - DIFF_W'(norm_ref));
        end
    end

    // Flatten the current metrics into the output vector layout.
    always_comb begin
        cur_pack = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            cur_pack[s*METRIC_W +: METRIC_W] = metric_q[s];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start always wins and restarts framing.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (blk_len != '0) ? ST_RUN : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if (accept && last_k) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (xfer && out_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Metric recursion, step counter and the output register slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            metric_q[0] <= '0;
            for (int s = 1; s < NUM_STATES; s++) begin
                metric_q[s] <= INIT_M;
            end
            k_q       <= '0;
            len_q     <= '0;
            zdone_q   <= 1'b0;
            out_valid <= 1'b0;
            alpha_o   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            zdone_q <= start && (blk_len == '0) && (state_q == ST_IDLE);
            if (start) begin
                metric_q[0] <= '0;
                for (int s = 1; s < NUM_STATES; s++) begin
                    metric_q[s] <= INIT_M;
                end
                k_q       <= '0;
                len_q     <= blk_len;
                out_valid <= 1'b0;
            end else if (accept) begin
                alpha_o   <= cur_pack;
                out_idx   <= k_q;
                out_last  <= last_k;
                out_valid <= 1'b1;
                for (int s = 0; s < NUM_STATES; s++) begin
                    metric_q[s] <= next_m[s];
                end
                k_q <= k_q + LEN_W'(1);
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alpha_recursion.sv
// Bench for alpha_recursion: a wide NORM_MODE=0 unit and a narrow
// NORM_MODE=1 unit share stimulus; a reference model scores both.
module tb_alpha_recursion;

    localparam int BW = 16;
    localparam int LW = 13;
    localparam int M0 = 19;
    localparam int M1 = 8;
    localparam int VW = 8 * M0;

    typedef longint vec_t [8];
    typedef struct {
        vec_t a;
        int   idx;
        bit   last;
    } exp_t;
    typedef struct {
        int g1;
        int g2;
        int e0 [8];
        int e1 [8];
    } tv_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [LW-1:0] blk_len;
    logic in_valid;
    logic out_ready;
    logic signed [BW-1:0] gamma1;
    logic signed [BW-1:0] gamma2;

    logic in_ready0, out_valid0, last0, busy0, done0;
    logic [8*M0-1:0] alpha0;
    logic [LW-1:0] idx0;
    logic in_ready1, out_valid1, last1, busy1, done1;
    logic [8*M1-1:0] alpha1;
    logic [LW-1:0] idx1;

    exp_t q0 [$];
    exp_t q1 [$];
    vec_t m0, m1;
    int k0, k1, mlen;
    bit zp;
    int xfers;
    int checks = 0;
    int errors = 0;
    logic [VW-1:0] cap0 [16];
    logic [VW-1:0] cap1 [16];
    tv_t tv [4];

    always #5 clk = ~clk;

    alpha_recursion #(
        .BRANCH_W(BW), .METRIC_W(M0), .NORM_MODE(0),
        .INIT_NEG(-128), .LEN_W(LW)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
        .in_valid(in_valid), .in_ready(in_ready0),
        .gamma1(gamma1), .gamma2(gamma2),
        .out_valid(out_valid0), .out_ready(out_ready),
        .alpha_o(alpha0), .out_idx(idx0), .out_last(last0),
        .busy(busy0), .done(done0)
    );

    alpha_recursion #(
        .BRANCH_W(BW), .METRIC_W(M1), .NORM_MODE(1),
        .INIT_NEG(-128), .LEN_W(LW)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
        .in_valid(in_valid), .in_ready(in_ready1),
        .gamma1(gamma1), .gamma2(gamma2),
        .out_valid(out_valid1), .out_ready(out_ready),
        .alpha_o(alpha1), .out_idx(idx1), .out_last(last1),
        .busy(busy1), .done(done1)
    );

    function automatic longint mx(input longint x, input longint y);
        return (x >= y) ? x : y;
    endfunction

    function automatic void init_vec(output vec_t v);
        v[0] = 0;
        for (int i = 1; i < 8; i++) v[i] = -128;
    endfunction

    function automatic void mstep(input vec_t a, input longint g1,
                                  input longint g2, input int w,
                                  input int mode, output vec_t r);
        vec_t n;
        longint rf, hi, lo;
        n[0] = mx(a[0] + g1, a[1] - g1);
        n[1] = mx(a[2] - g2, a[3] + g2);
        n[2] = mx(a[4] + g2, a[5] - g2);
        n[3] = mx(a[6] - g1, a[7] + g1);
        n[4] = mx(a[0] - g1, a[1] + g1);
        n[5] = mx(a[2] + g2, a[3] - g2);
        n[6] = mx(a[4] - g2, a[5] + g2);
        n[7] = mx(a[6] + g1, a[7] - g1);
        rf = n[0];
        if (mode == 1) for (int i = 1; i < 8; i++) rf = mx(rf, n[i]);
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        for (int i = 0; i < 8; i++) begin
            r[i] = n[i] - rf;
            if (r[i] > hi) r[i] = hi;
            if (r[i] < lo) r[i] = lo;
        end
    endfunction

    function automatic logic [VW-1:0] packv(input vec_t a, input int w);
        logic [VW-1:0] r;
        r = '0;
        for (int s = 0; s < 8; s++)
            for (int b = 0; b < w; b++) r[s*w+b] = a[s][b];
        return r;
    endfunction

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chkv(input string nm, input logic [VW-1:0] act,
                        input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Scoreboard: pop/compare on transfers, push on accepted beats.
    always @(negedge clk) begin
        exp_t e;
        vec_t t;
        bit ed0, ed1;
        if (rst) begin
            q0.delete();
            q1.delete();
            zp = 1'b0;
        end else begin
            ed0 = zp;
            ed1 = zp;
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    chk("spurious_out0", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chkv("alpha0", alpha0, packv(e.a, M0));
                    chk("idx0", idx0, e.idx);
                    chk("last0", last0, e.last);
                    ed0 = e.last && !start;
                    cap0[idx0[3:0]] = alpha0;
                    xfers++;
                end
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) begin
                    chk("spurious_out1", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chkv("alpha1", VW'(alpha1), packv(e.a, M1));
                    chk("idx1", idx1, e.idx);
                    chk("last1", last1, e.last);
                    ed1 = e.last && !start;
                    cap1[idx1[3:0]] = VW'(alpha1);
                end
            end
            chk("done0", done0, ed0);
            chk("done1", done1, ed1);
            zp = start && (blk_len == '0);
            if (start) begin
                q0.delete();
                q1.delete();
                init_vec(m0);
                init_vec(m1);
                k0 = 0;
                k1 = 0;
                mlen = int'(blk_len);
            end else begin
                if (in_valid && in_ready0) begin
                    e.a = m0;
                    e.idx = k0;
                    e.last = (k0 == mlen - 1);
                    q0.push_back(e);
                    mstep(m0, longint'(gamma1), longint'(gamma2), M0, 0, t);
                    m0 = t;
                    k0++;
                end
                if (in_valid && in_ready1) begin
                    e.a = m1;
                    e.idx = k1;
                    e.last = (k1 == mlen - 1);
                    q1.push_back(e);
                    mstep(m1, longint'(gamma1), longint'(gamma2), M1, 1, t);
                    m1 = t;
                    k1++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start = 1'b1;
        blk_len = LW'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int g1, input int g2);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        in_valid = 1'b1;
        gamma1 = BW'(g1);
        gamma2 = BW'(g2);
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready0;
            n++;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || out_valid0) && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", n < 200, 1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, out_valid0, 0);
        chkv({tag, "_alpha"}, alpha0, '0);
        chk({tag, "_idx"}, idx0, 0);
        chk({tag, "_last"}, last0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_ready"}, in_ready0, 0);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_busy1"}, busy1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t iv, ev;
        logic [VW-1:0] init0;
        int x0;

        tv[0] = '{10, 0,
                  '{0, -138, -138, -128, -20, -138, -138, -128},
                  '{0, -128, -128, -128, -20, -128, -128, -128}};
        tv[1] = '{100, 0,
                  '{0, -228, -228, -128, -128, -228, -228, -128},
                  '{0, -128, -128, -128, -128, -128, -128, -128}};
        tv[2] = '{-50, 0,
                  '{0, -78, -78, -28, 100, -78, -78, -28},
                  '{-100, -128, -128, -128, 0, -128, -128, -128}};
        tv[3] = '{0, 20,
                  '{0, -108, -108, -128, 0, -108, -108, -128},
                  '{0, -108, -108, -128, 0, -108, -108, -128}};

        init_vec(iv);
        init0 = packv(iv, M0);
        xfers = 0;
        rst = 1'b0;
        start = 1'b0;
        blk_len = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        gamma1 = '0;
        gamma2 = '0;
        #2 rst = 1'b1;
        tick();
        tick();
        chk_reset_outs("reset");
        rst = 1'b0;
        tick();

        // Single-step block: latency, last flag, done in the same cycle.
        do_start(1);
        send(10, 0);
        chk("b1_valid", out_valid0, 1);
        chkv("b1_alpha", alpha0, init0);
        chk("b1_idx", idx0, 0);
        chk("b1_last", last0, 1);
        chk("b1_done", done0, 1);
        tick();
        chk("b1_busy_after", busy0, 0);
        chk("b1_valid_after", out_valid0, 0);

        // One trellis step from the init vector, both normalisations.
        for (int i = 0; i < 4; i++) begin
            cap0[1] = '0;
            cap1[1] = '0;
            do_start(2);
            send(tv[i].g1, tv[i].g2);
            send(0, 0);
            wait_idle();
            tick();
            for (int s = 0; s < 8; s++) ev[s] = tv[i].e0[s];
            chkv($sformatf("tbl%0d_n0", i), cap0[1], packv(ev, M0));
            for (int s = 0; s < 8; s++) ev[s] = tv[i].e1[s];
            chkv($sformatf("tbl%0d_n1", i), cap1[1], packv(ev, M1));
        end

        // Backpressure holds the output and blocks new beats.
        x0 = xfers;
        do_start(4);
        send(5, 3);
        out_ready = 1'b0;
        in_valid = 1'b1;
        gamma1 = BW'(7);
        gamma2 = BW'(-2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ready", in_ready0, 0);
            chk("bp_valid", out_valid0, 1);
            chk("bp_idx", idx0, 0);
            chkv("bp_alpha", alpha0, init0);
        end
        out_ready = 1'b1;
        send(7, -2);
        send(-4, 9);
        send(1, 1);
        wait_idle();
        tick();
        chk("bp_count", xfers - x0, 4);

        // Random gammas with a flickering downstream ready.
        x0 = xfers;
        do_start(12);
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send(int'($urandom_range(600)) - 300,
                         int'($urandom_range(600)) - 300);
            end
            begin
                repeat (40) begin
                    out_ready = 1'($urandom_range(1));
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();
        tick();
        chk("rnd_count", xfers - x0, 12);

        // Abort mid-block: pending vector dropped, no done.
        do_start(8);
        for (int i = 0; i < 5; i++) send(i * 3, -i);
        out_ready = 1'b0;
        do_start(3);
        chk("ab_valid", out_valid0, 0);
        chk("ab_done", done0, 0);
        chk("ab_busy", busy0, 1);
        out_ready = 1'b1;
        send(2, 2);
        chk("ab_idx", idx0, 0);
        chkv("ab_alpha", alpha0, init0);
        send(-6, 4);
        send(3, -9);
        wait_idle();
        tick();

        // Zero-length block: done only, one cycle late.
        do_start(0);
        chk("z_done", done0, 1);
        chk("z_busy", busy0, 0);
        chk("z_valid", out_valid0, 0);
        tick();
        chk("z_done_clear", done0, 0);

        // Asynchronous reset in the middle of a block.
        do_start(6);
        send(4, 1);
        send(-3, 8);
        #2 rst = 1'b1;
        #1;
        chk_reset_outs("arst");
        tick();
        rst = 1'b0;
        tick();
        do_start(1);
        send(0, 20);
        wait_idle();
        tick();

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
